instr_fetch_unit: RTL and testbench

- Instruction-side counterpart of the single-cycle control unit: produces the 32-bit instruction word the controller decodes and consumes its branch-taken signal (PCSrc) plus target.
- Owns the fetch PC; issues pipelined word reads to instruction memory (variable latency, in-order responses); buffers returned words in a prefetch FIFO; presents them to the core with a valid/ready handshake.
- On a taken branch, flushes buffered and in-flight instructions and restarts fetch at the target.

---
 rtl/instr_fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues pipelined imem reads, buffers responses in a
// prefetch FIFO and redirects on taken branches. Define FETCH_STATS_EN for saturating counters.
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] Instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        PCSrc,
    input  logic [31:0] branch_target
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_flushed,
    output logic [15:0] stat_redirects
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StBoot, StRun, StDrain} state_e;

    state_e            state_q, state_d;
    logic [31:0]       fpc_q, fpc_d;
    logic [31:0]       rpc_q, rpc_d;
    logic [CntW-1:0]   outstanding_q, outstanding_d;
    logic [CntW-1:0]   drop_q, drop_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic [31:0]       mem_data_q [DEPTH];
    logic [31:0]       mem_pc_q   [DEPTH];

    logic        req_fire;
    logic        pop;
    logic        redirect;
    logic        push;
    logic        space;
    logic [31:0] target;
    logic        unused_target_lsbs;

    assign target             = {branch_target[31:2], 2'b00};
    assign unused_target_lsbs = ^branch_target[1:0];

    // Counting in-flight reads against free slots means every response always has a home.
    assign space    = ({1'b0, count_q} + {1'b0, outstanding_q}) < (CntW + 1)'(DEPTH);
    assign imem_req = (state_q == StRun) && space;
    assign imem_addr = fpc_q;
    assign req_fire = imem_req & imem_gnt;

    assign instr_valid = (count_q != '0);
    assign Instr       = mem_data_q[rptr_q];
    assign instr_pc    = mem_pc_q[rptr_q];
    assign pop         = instr_valid & instr_ready;
    assign redirect    = pop & PCSrc;
    assign push        = imem_rvalid && (drop_q == '0) && !redirect;

    always_comb begin
        state_d       = state_q;
        fpc_d         = fpc_q;
        rpc_d         = rpc_q;
        outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(imem_rvalid);
        drop_d        = drop_q;
        count_d       = count_q + CntW'(push) - CntW'(pop);
        wptr_d        = push ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d        = pop ? rptr_q + PtrW'(1) : rptr_q;

        if (req_fire) begin
            fpc_d = fpc_q + 32'd4;
        end
        if (push) begin
            rpc_d = rpc_q + 32'd4;
        end
        if (imem_rvalid && (drop_q != '0)) begin
            drop_d = drop_q - CntW'(1);
        end

        case (state_q)
            StBoot:  state_d = StRun;
            StRun:   state_d = StRun;
            StDrain: if (drop_q == '0) state_d = StRun;
            default: state_d = StBoot;
        endcase

        // Everything still in flight after this edge (including a same-cycle grant) is stale.
        if (redirect) begin
            fpc_d   = target;
            rpc_d   = target;
            drop_d  = outstanding_d;
            count_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            state_d = ((state_q == StDrain) || (outstanding_d != '0)) ? StDrain : StRun;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StBoot;
            fpc_q         <= RESET_PC;
            rpc_q         <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
        end else begin
            state_q       <= state_d;
            fpc_q         <= fpc_d;
            rpc_q         <= rpc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_pc_q[i]   <= '0;
            end
        end else if (push) begin
            mem_data_q[wptr_q] <= imem_rdata;
            mem_pc_q[wptr_q]   <= rpc_q;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetched_q;
    logic [31:0] flushed_q;
    logic [15:0] redirects_q;
    logic        discard;
    logic [32:0] flushed_sum;

    assign discard     = imem_rvalid && ((drop_q != '0) || redirect);
    // On a redirect the branch itself is consumed, so only the entries behind it are flushed.
    assign flushed_sum = {1'b0, flushed_q} + 33'(discard)
                       + (redirect ? 33'(count_q - CntW'(1)) : 33'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetched_q   <= '0;
            flushed_q   <= '0;
            redirects_q <= '0;
        end else begin
            if (push && (fetched_q != '1)) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (redirect && (redirects_q != '1)) begin
                redirects_q <= redirects_q + 16'd1;
            end
            flushed_q <= flushed_sum[32] ? '1 : flushed_sum[31:0];
        end
    end

    assign stat_fetched   = fetched_q;
    assign stat_flushed   = flushed_q;
    assign stat_redirects = redirects_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order, variable-latency instruction memory model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] Instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        PCSrc;
    logic [31:0] branch_target;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_flushed;
    logic [15:0] stat_redirects;
`endif

    int total = 0;
    int bad   = 0;
    int lat   = 1;
    int mcyc  = 0;
    int n_gnt = 0;
    int g0;

    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    instr_fetch_unit #(
        .DEPTH   (4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .Instr        (Instr),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready),
        .PCSrc        (PCSrc),
        .branch_target(branch_target)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched  (stat_fetched),
        .stat_flushed  (stat_flushed),
        .stat_redirects(stat_redirects)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: a read granted in cycle N returns ~addr in cycle N+lat.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            mcyc++;
            if (!reset) begin
                pend_addr.delete();
                pend_due.delete();
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end else if (pend_addr.size() > 0 && pend_due[0] <= mcyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = ~pend_addr[0];
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
            @(negedge clk);
            if (reset && imem_req && imem_gnt) begin
                pend_addr.push_back(imem_addr);
                pend_due.push_back(mcyc + lat);
                n_gnt++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    // Waits (bounded) for a valid instruction, checks it, then lets it be consumed.
    task automatic expect_instr(input string tag, input logic [31:0] pc);
        int n = 0;
        while (!instr_valid && n < 30) begin
            cyc();
            n++;
        end
        chk1({tag, " valid"}, instr_valid, 1'b1);
        chk({tag, " pc"}, instr_pc, pc);
        chk({tag, " instr"}, Instr, ~pc);
        cyc();
    endtask

    task automatic do_branch(input logic [31:0] t);
        int n = 0;
        while (!instr_valid && n < 30) begin
            cyc();
            n++;
        end
        chk1("branch valid", instr_valid, 1'b1);
        PCSrc         = 1'b1;
        branch_target = t;
        cyc();
        PCSrc = 1'b0;
    endtask

    initial begin
        logic [31:0] e;
        reset         = 1'b0;
        imem_gnt      = 1'b1;
        instr_ready   = 1'b1;
        PCSrc         = 1'b0;
        branch_target = '0;
        lat           = 1;

        // Reset values
        cyc();
        cyc();
        chk1("rst req", imem_req, 1'b0);
        chk("rst addr", imem_addr, 32'h0);
        chk1("rst valid", instr_valid, 1'b0);
        chk("rst instr", Instr, 32'h0);
        chk("rst pc", instr_pc, 32'h0);
`ifdef FETCH_STATS_EN
        chk("rst fetched", stat_fetched, 32'h0);
        chk("rst flushed", stat_flushed, 32'h0);
        chk("rst redirects", {16'h0, stat_redirects}, 32'h0);
`endif

        // Streaming at latency 1: boot cycle, then one word per cycle
        reset = 1'b1;
        chk1("boot req", imem_req, 1'b0);
        cyc();
        chk1("t1 req", imem_req, 1'b1);
        chk("t1 addr0", imem_addr, 32'h0);
        chk1("t1 valid0", instr_valid, 1'b0);
        cyc();
        chk("t1 addr1", imem_addr, 32'h4);
        chk1("t1 valid1", instr_valid, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            e = 32'(4 * k);
            chk1("t1 valid", instr_valid, 1'b1);
            chk("t1 pc", instr_pc, e);
            chk("t1 instr", Instr, ~e);
            chk("t1 addr", imem_addr, e + 32'h8);
        end

        // Back-pressure: FIFO fills after exactly DEPTH grants, head stays put
        instr_ready = 1'b0;
        do_reset();
        g0 = n_gnt;
        repeat (6) cyc();
        chk1("t2 valid", instr_valid, 1'b1);
        chk("t2 pc early", instr_pc, 32'h0);
        repeat (6) cyc();
        chk("t2 grants", 32'(n_gnt - g0), 32'd4);
        chk1("t2 req", imem_req, 1'b0);
        chk("t2 pc late", instr_pc, 32'h0);
        chk("t2 instr late", Instr, 32'hFFFF_FFFF);
        instr_ready = 1'b1;
        expect_instr("t2 i0", 32'h0);
        expect_instr("t2 i1", 32'h4);
        expect_instr("t2 i2", 32'h8);
        expect_instr("t2 i3", 32'hC);
        expect_instr("t2 i4", 32'h10);

        // Latency 3: redirect with three reads in flight (third granted in the redirect cycle)
        instr_ready = 1'b0;
        lat         = 3;
        do_reset();
        cyc();
        cyc();
        imem_gnt = 1'b0;
        cyc();
        cyc();
        cyc();
        chk1("t3 head valid", instr_valid, 1'b1);
        chk("t3 head pc", instr_pc, 32'h0);
        imem_gnt = 1'b1;
        cyc();
        cyc();
        chk1("t3 req at redirect", imem_req, 1'b1);
        instr_ready   = 1'b1;
        PCSrc         = 1'b1;
        branch_target = 32'h100;
        cyc();
        PCSrc = 1'b0;
        chk1("t3 drain req", imem_req, 1'b0);
        chk("t3 drain addr", imem_addr, 32'h100);
        chk1("t3 drain valid", instr_valid, 1'b0);
        expect_instr("t3 i0", 32'h100);
        expect_instr("t3 i1", 32'h104);

        // Redirect coinciding with rvalid and grant; target LSBs ignored
        instr_ready = 1'b0;
        lat         = 1;
        do_reset();
        cyc();
        cyc();
        cyc();
        chk1("t4 head valid", instr_valid, 1'b1);
        chk("t4 head pc", instr_pc, 32'h0);
        chk1("t4 rvalid present", imem_rvalid, 1'b1);
        chk1("t4 req present", imem_req, 1'b1);
        instr_ready   = 1'b1;
        PCSrc         = 1'b1;
        branch_target = 32'h203;
        cyc();
        PCSrc = 1'b0;
        chk1("t4 drain req", imem_req, 1'b0);
        chk("t4 drain addr", imem_addr, 32'h200);
        chk1("t4 drain valid", instr_valid, 1'b0);
        expect_instr("t4 i0", 32'h200);
        expect_instr("t4 i1", 32'h204);

        // PC wraps from the top of the address space
        do_branch(32'hFFFF_FFFF);
        expect_instr("t5 i0", 32'hFFFF_FFFC);
        expect_instr("t5 i1", 32'h0);
        expect_instr("t5 i2", 32'h4);
`ifdef FETCH_STATS_EN
        chk("t5 redirects", {16'h0, stat_redirects}, 32'd2);
`endif

        // Asynchronous reset mid-burst
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk1("t6 req", imem_req, 1'b0);
        chk("t6 addr", imem_addr, 32'h0);
        chk1("t6 valid", instr_valid, 1'b0);
        chk("t6 instr", Instr, 32'h0);
        chk("t6 pc", instr_pc, 32'h0);
`ifdef FETCH_STATS_EN
        chk("t6 fetched", stat_fetched, 32'h0);
        chk("t6 flushed", stat_flushed, 32'h0);
        chk("t6 redirects", {16'h0, stat_redirects}, 32'h0);
`endif
        cyc();
        cyc();
        reset = 1'b1;
        expect_instr("t6 i0", 32'h0);
        expect_instr("t6 i1", 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
